scpad_head_arb: RTL and testbench

Per-scratchpad request head that buffers frontend (FE) and backend (BE) requests, arbitrates them with BE priority plus FE anti-starvation, and presents one tagged request per cycle to the write/read crossbar path (head_stomach_req). It sits between the FE/BE request ports and the crossbar / SRAM-controller body. It absorbs downstream backpressure (w_stall / r_stall) and converts it into registered fe_stall / be_stall.

---
 rtl/scpad_pkg.sv | 23 ++
 rtl/scpad_head_arb_if.sv | 45 ++++
 rtl/scpad_req_fifo.sv | 46 ++++
 rtl/scpad_head_arb.sv | 114 +++++++++++
 tb/tb_scpad_head_arb.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scpad_pkg.sv
// Shared types and default sizing for the scratchpad request head.
package scpad_pkg;

  localparam int unsigned ADDR_W_DEF       = 10;
  localparam int unsigned DATA_W_DEF       = 256;
  localparam int unsigned MASK_W_DEF       = 32;
  localparam int unsigned FIFO_DEPTH_DEF   = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 8;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [MASK_W_DEF-1:0] mask;
    src_e                  src;
  } head_req_t;

endpackage

// File: rtl/scpad_head_arb_if.sv
// FE/BE request ports, source backpressure and the head_stomach_req output bundle.
interface scpad_head_arb_if
  import scpad_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned MASK_W = MASK_W_DEF
);
  logic              fe_req_valid;
  logic              fe_req_write;
  logic [ADDR_W-1:0] fe_req_addr;
  logic [DATA_W-1:0] fe_req_wdata;
  logic [MASK_W-1:0] fe_req_mask;
  logic              be_req_valid;
  logic              be_req_write;
  logic [ADDR_W-1:0] be_req_addr;
  logic [DATA_W-1:0] be_req_wdata;
  logic [MASK_W-1:0] be_req_mask;
  logic              fe_stall;
  logic              be_stall;
  logic              w_stall;
  logic              r_stall;
  logic              out_valid;
  logic              out_write;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_wdata;
  logic [MASK_W-1:0] out_mask;
  logic              out_src;

  modport master (
    output fe_req_valid, fe_req_write, fe_req_addr, fe_req_wdata, fe_req_mask,
    output be_req_valid, be_req_write, be_req_addr, be_req_wdata, be_req_mask,
    output w_stall, r_stall,
    input  fe_stall, be_stall,
    input  out_valid, out_write, out_addr, out_wdata, out_mask, out_src
  );

  modport slave (
    input  fe_req_valid, fe_req_write, fe_req_addr, fe_req_wdata, fe_req_mask,
    input  be_req_valid, be_req_write, be_req_addr, be_req_wdata, be_req_mask,
    input  w_stall, r_stall,
    output fe_stall, be_stall,
    output out_valid, out_write, out_addr, out_wdata, out_mask, out_src
  );
endinterface

// File: rtl/scpad_req_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so pointers wrap naturally.
module scpad_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/scpad_head_arb.sv
// Scratchpad request head: buffers FE/BE requests, arbitrates BE-first with FE
// anti-starvation, and holds one tagged request for the crossbar path.
module scpad_head_arb
  import scpad_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MASK_W       = MASK_W_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic             clk,
  input logic             n_rst,
  scpad_head_arb_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT+1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
    src_e              src;
  } req_t;

  req_t             fe_in_c, be_in_c, fe_head, be_head, out_q;
  logic             out_valid_q, fe_stall_q, be_stall_q;
  logic [STV_W-1:0] starve_q, starve_nxt_c;
  logic [CNT_W-1:0] fe_count, be_count, fe_cnt_nxt_c, be_cnt_nxt_c;
  logic             fe_full, be_full, fe_empty, be_empty;
  logic             fe_push_c, be_push_c, fe_grant_c, be_grant_c, fire_c, free_c;

  scpad_req_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fe_fifo (
    .clk(clk), .rst(n_rst), .push(fe_push_c), .pop(fe_grant_c), .wr_data(fe_in_c),
    .rd_data(fe_head), .full(fe_full), .empty(fe_empty), .count(fe_count)
  );

  scpad_req_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_be_fifo (
    .clk(clk), .rst(n_rst), .push(be_push_c), .pop(be_grant_c), .wr_data(be_in_c),
    .rd_data(be_head), .full(be_full), .empty(be_empty), .count(be_count)
  );

  // Arbitration, push qualification and next-state for counters/stalls.
  always_comb begin
    fe_in_c       = '0;
    be_in_c       = '0;
    fe_grant_c    = 1'b0;
    be_grant_c    = 1'b0;
    starve_nxt_c  = starve_q;

    fe_in_c.write = bus.fe_req_write;
    fe_in_c.addr  = bus.fe_req_addr;
    fe_in_c.wdata = bus.fe_req_wdata;
    fe_in_c.mask  = bus.fe_req_mask;
    fe_in_c.src   = SRC_FE;
    be_in_c.write = bus.be_req_write;
    be_in_c.addr  = bus.be_req_addr;
    be_in_c.wdata = bus.be_req_wdata;
    be_in_c.mask  = bus.be_req_mask;
    be_in_c.src   = SRC_BE;

    fe_push_c = bus.fe_req_valid && !fe_stall_q && !fe_full;
    be_push_c = bus.be_req_valid && !be_stall_q && !be_full;

    fire_c = out_valid_q && !(out_q.write ? bus.w_stall : bus.r_stall);
    free_c = !out_valid_q || fire_c;

    if (free_c) begin
      if (!fe_empty && (be_empty || starve_q == STV_W'(STARVE_LIMIT))) fe_grant_c = 1'b1;
      else if (!be_empty)                                              be_grant_c = 1'b1;
    end

    if (fe_empty || fe_grant_c)
      starve_nxt_c = '0;
    else if (be_grant_c && starve_q != STV_W'(STARVE_LIMIT))
      starve_nxt_c = starve_q + STV_W'(1);

    fe_cnt_nxt_c = fe_count + CNT_W'(fe_push_c) - CNT_W'(fe_grant_c);
    be_cnt_nxt_c = be_count + CNT_W'(be_push_c) - CNT_W'(be_grant_c);
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      starve_q    <= '0;
      fe_stall_q  <= 1'b1;
      be_stall_q  <= 1'b1;
    end else begin
      starve_q   <= starve_nxt_c;
      fe_stall_q <= (fe_cnt_nxt_c == CNT_W'(FIFO_DEPTH));
      be_stall_q <= (be_cnt_nxt_c == CNT_W'(FIFO_DEPTH));
      if (fe_grant_c) begin
        out_q       <= fe_head;
        out_valid_q <= 1'b1;
      end else if (be_grant_c) begin
        out_q       <= be_head;
        out_valid_q <= 1'b1;
      end else if (fire_c) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.fe_stall  = fe_stall_q;
  assign bus.be_stall  = be_stall_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_write = out_q.write;
  assign bus.out_addr  = out_q.addr;
  assign bus.out_wdata = out_q.wdata;
  assign bus.out_mask  = out_q.mask;
  assign bus.out_src   = 1'(out_q.src);
endmodule

// File: tb/tb_scpad_head_arb.sv
// Bench for scpad_head_arb: directed scenarios plus a randomized run, all
// checked against a queue-based model of the arbitration rules.
module tb_scpad_head_arb;
  import scpad_pkg::*;

  localparam int unsigned DEPTH = FIFO_DEPTH_DEF;
  localparam int unsigned LIMIT = STARVE_LIMIT_DEF;
  localparam int unsigned VW    = 3 + $bits(head_req_t);

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  scpad_head_arb_if bus ();

  scpad_head_arb dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  head_req_t fe_drv, be_drv;
  logic      fe_v, be_v, w_stall, r_stall;

  assign bus.fe_req_valid = fe_v;
  assign bus.fe_req_write = fe_drv.write;
  assign bus.fe_req_addr  = fe_drv.addr;
  assign bus.fe_req_wdata = fe_drv.wdata;
  assign bus.fe_req_mask  = fe_drv.mask;
  assign bus.be_req_valid = be_v;
  assign bus.be_req_write = be_drv.write;
  assign bus.be_req_addr  = be_drv.addr;
  assign bus.be_req_wdata = be_drv.wdata;
  assign bus.be_req_mask  = be_drv.mask;
  assign bus.w_stall      = w_stall;
  assign bus.r_stall      = r_stall;

  int checks = 0;
  int errors = 0;

  // Reference model: per-source queues, one output slot, a starvation tally.
  head_req_t fe_q[$];
  head_req_t be_q[$];
  head_req_t m_out;
  logic      m_valid    = 1'b0;
  logic      m_fe_stall = 1'b1;
  logic      m_be_stall = 1'b1;
  int        starve     = 0;

  function automatic head_req_t rand_req();
    head_req_t r;
    r.write = 1'($urandom_range(0, 1));
    r.addr  = 10'($urandom());
    for (int i = 0; i < 8; i++) r.wdata[i*32 +: 32] = $urandom();
    r.mask  = $urandom();
    r.src   = SRC_FE;
    return r;
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    head_req_t z = '0;
    return {m_valid, m_fe_stall, m_be_stall, (m_valid ? m_out : z)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    head_req_t z = '0;
    head_req_t d;
    d.write = bus.out_write;
    d.addr  = bus.out_addr;
    d.wdata = bus.out_wdata;
    d.mask  = bus.out_mask;
    d.src   = src_e'(bus.out_src);
    return {bus.out_valid, bus.fe_stall, bus.be_stall, (bus.out_valid === 1'b1 ? d : z)};
  endfunction

  // Advance the model by one cycle using the driven inputs, then clock the DUT.
  task automatic cycle();
    bit fire, free, fw, bw;
    head_req_t in;
    if (n_rst) begin
      fe_q.delete(); be_q.delete();
      m_valid = 1'b0; m_out = '0; starve = 0;
      m_fe_stall = 1'b1; m_be_stall = 1'b1;
    end else begin
      fire = m_valid && !(m_out.write ? w_stall : r_stall);
      free = !m_valid || fire;
      fw = free && fe_q.size() != 0 && (be_q.size() == 0 || starve == LIMIT);
      bw = free && !fw && be_q.size() != 0;
      if (fe_q.size() == 0 || fw) starve = 0;
      else if (bw && starve < LIMIT) starve++;
      if (fw)        begin m_out = fe_q.pop_front(); m_valid = 1'b1; end
      else if (bw)   begin m_out = be_q.pop_front(); m_valid = 1'b1; end
      else if (fire) m_valid = 1'b0;
      if (fe_v && !m_fe_stall) begin in = fe_drv; in.src = SRC_FE; fe_q.push_back(in); end
      if (be_v && !m_be_stall) begin in = be_drv; in.src = SRC_BE; be_q.push_back(in); end
      m_fe_stall = (fe_q.size() == DEPTH);
      m_be_stall = (be_q.size() == DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fe_v = 1'b0; be_v = 1'b0; w_stall = 1'b0; r_stall = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    n_rst = 1'b1; fe_v = 1'b0; be_v = 1'b0; w_stall = 1'b0; r_stall = 1'b0;
    fe_drv = '0; be_drv = '0;
    cycle(); cycle();
    checks++;
    if ({bus.out_valid, bus.fe_stall, bus.be_stall} !== 3'b011) begin
      errors++; $display("FAIL reset_hold: got %b exp 011", {bus.out_valid, bus.fe_stall, bus.be_stall});
    end
    n_rst = 1'b0;
    cycle();
    checks++;
    if ({bus.out_valid, bus.fe_stall, bus.be_stall} !== 3'b000) begin
      errors++; $display("FAIL reset_release: got %b exp 000", {bus.out_valid, bus.fe_stall, bus.be_stall});
    end
  endtask

  task automatic test_single_fe();
    logic saw_stall = 1'b0;
    fe_drv = rand_req(); fe_drv.write = 1'b0; fe_drv.addr = 10'h005;
    fe_v = 1'b1;
    cycle();
    fe_v = 1'b0;
    saw_stall |= bus.fe_stall;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_t1: out_valid got %b exp 0", bus.out_valid); end
    cycle();
    saw_stall |= bus.fe_stall;
    checks++;
    if ({bus.out_valid, bus.out_src, bus.out_write, bus.out_addr} !== {3'b100, 10'h005}) begin
      errors++; $display("FAIL single_t2: got v=%b s=%b w=%b a=%h exp v=1 s=0 w=0 a=005",
                         bus.out_valid, bus.out_src, bus.out_write, bus.out_addr);
    end
    cycle();
    saw_stall |= bus.fe_stall;
    checks++;
    if ({bus.out_valid, saw_stall} !== 2'b00) begin
      errors++; $display("FAIL single_t3: out_valid=%b fe_stall_seen=%b exp 0 0", bus.out_valid, saw_stall);
    end
  endtask

  task automatic test_both_sources();
    fe_drv = rand_req(); fe_drv.write = 1'b0; fe_drv.addr = 10'h010;
    be_drv = rand_req(); be_drv.write = 1'b0; be_drv.addr = 10'h020;
    fe_v = 1'b1; be_v = 1'b1;
    cycle();
    fe_v = 1'b0; be_v = 1'b0;
    cycle();
    checks++;
    if ({bus.out_valid, bus.out_src, bus.out_addr} !== {2'b11, 10'h020}) begin
      errors++; $display("FAIL both_be_first: got v=%b s=%b a=%h exp v=1 s=1 a=020", bus.out_valid, bus.out_src, bus.out_addr);
    end
    cycle();
    checks++;
    if ({bus.out_valid, bus.out_src, bus.out_addr} !== {2'b10, 10'h010}) begin
      errors++; $display("FAIL both_fe_second: got v=%b s=%b a=%h exp v=1 s=0 a=010", bus.out_valid, bus.out_src, bus.out_addr);
    end
    cycle();
    checks++;
    if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL both_idle: got %h exp %h", dut_vec(), mdl_vec()); end
  endtask

  // Continuous BE traffic with two queued FE requests: each FE waits exactly LIMIT BE grants.
  task automatic test_starvation();
    int nbe[2];
    int seg = 0;
    nbe[0] = 0; nbe[1] = 0;
    be_v = 1'b1;
    repeat (3) begin be_drv = rand_req(); cycle(); end
    fe_drv = rand_req(); fe_v = 1'b1; be_drv = rand_req();
    cycle();
    fe_drv = rand_req();
    for (int k = 0; k < 40 && seg < 2; k++) begin
      be_drv = rand_req();
      cycle();
      fe_v = 1'b0;
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL starve_step %0d: got %h exp %h", k, dut_vec(), mdl_vec()); end
      if (bus.out_valid === 1'b1 && bus.out_src === 1'b1) nbe[seg]++;
      else if (bus.out_valid === 1'b1 && bus.out_src === 1'b0) seg++;
    end
    checks++;
    if (seg != 2 || nbe[0] != int'(LIMIT) || nbe[1] != int'(LIMIT)) begin
      errors++; $display("FAIL starve_count: got fe_grants=%0d be_before=%0d,%0d exp 2 %0d,%0d", seg, nbe[0], nbe[1], LIMIT, LIMIT);
    end
    idle(6);
  endtask

  task automatic test_write_hold();
    head_req_t held;
    int nout = 0;
    idle(4);
    w_stall = 1'b1;
    be_drv = rand_req(); be_drv.write = 1'b1; be_drv.addr = 10'h0AA;
    held = be_drv; held.src = SRC_BE;
    be_v = 1'b1;
    cycle();
    be_v = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      fe_drv = rand_req(); be_drv = rand_req(); fe_v = 1'b1; be_v = 1'b1;
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || dut_vec() !== {3'b1, 2'bxx, held} && dut_vec() !== mdl_vec()
          || {bus.out_write, bus.out_addr, bus.out_wdata, bus.out_mask, bus.out_src} !== held) begin
        errors++; $display("FAIL hold_stable %0d: got %h exp %h", i, dut_vec(), {3'b100, held});
      end
    end
    checks++;
    if ({bus.fe_stall, bus.be_stall} !== 2'b11) begin
      errors++; $display("FAIL hold_stalls: got %b exp 11", {bus.fe_stall, bus.be_stall});
    end
    fe_v = 1'b0; be_v = 1'b0; w_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.out_valid === 1'b1) nout++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL hold_drain %0d: got %h exp %h", i, dut_vec(), mdl_vec()); end
    end
    checks++;
    if (nout != 2 * int'(DEPTH)) begin errors++; $display("FAIL hold_count: got %0d exp %0d", nout, 2 * DEPTH); end
  endtask

  task automatic test_rstall_write();
    idle(3);
    r_stall = 1'b1;
    be_drv = rand_req(); be_drv.write = 1'b1; be_v = 1'b1;
    cycle();
    be_v = 1'b0;
    cycle();
    checks++;
    if ({bus.out_valid, bus.out_write} !== 2'b11) begin
      errors++; $display("FAIL rstall_load: got v=%b w=%b exp 1 1", bus.out_valid, bus.out_write);
    end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstall_fire: out_valid got %b exp 0", bus.out_valid); end
    r_stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic leaked = 1'b0;
    idle(3);
    w_stall = 1'b1;
    be_drv = rand_req(); be_drv.write = 1'b1; be_v = 1'b1;
    cycle();
    be_v = 1'b0; fe_v = 1'b1;
    fe_drv = rand_req(); cycle();
    fe_drv = rand_req(); cycle();
    fe_v = 1'b0;
    checks++;
    if ({bus.out_valid, bus.fe_stall} !== 2'b11) begin
      errors++; $display("FAIL midrst_pre: got v=%b fe_stall=%b exp 1 1", bus.out_valid, bus.fe_stall);
    end
    n_rst = 1'b1;
    cycle();
    checks++;
    if ({bus.out_valid, bus.fe_stall, bus.be_stall} !== 3'b011) begin
      errors++; $display("FAIL midrst_hold: got %b exp 011", {bus.out_valid, bus.fe_stall, bus.be_stall});
    end
    n_rst = 1'b0; w_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      leaked |= (bus.out_valid !== 1'b0);
    end
    checks++;
    if (leaked !== 1'b0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL midrst_after: leaked=%b got %h exp %h", leaked, dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      n_rst   = ($urandom_range(0, 299) == 0);
      fe_v    = ($urandom_range(0, 9) < 6);
      be_v    = ($urandom_range(0, 9) < 6);
      w_stall = ($urandom_range(0, 3) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      fe_drv  = rand_req();
      be_drv  = rand_req();
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random %0d: got %h exp %h", i, dut_vec(), mdl_vec()); end
    end
    n_rst = 1'b0;
    idle(6);
  endtask

  initial begin
    test_reset();
    test_single_fe();
    test_both_sources();
    test_starvation();
    test_write_hold();
    test_rstall_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
